// File: rtl/safe_sync_ctrl_if.sv
// safe_sync_ctrl_if: control/status bundle between the safety CSR block, the harts and the lockstep sync controller
interface safe_sync_ctrl_if #(
    parameter int NHARTS    = 3,
    parameter int TIMEOUT_W = 16
);
    logic                 safe_mode_i;
    logic                 safe_config_i;
    logic [NHARTS-1:0]    active_mask_i;
    logic [NHARTS-1:0]    master_core_i;
    logic [NHARTS-1:0]    initial_sync_i;
    logic [NHARTS-1:0]    halt_ack_i;
    logic [NHARTS-1:0]    hart_wfi_i;
    logic [NHARTS-1:0]    hart_intc_ack_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [NHARTS-1:0]    interrupt_halt_o;
    logic [NHARTS-1:0]    interrupt_sync_o;
    logic                 single_bus_o;
    logic                 sync_busy_o;
    logic                 sync_done_o;
    logic                 sync_error_o;
    modport master (
        output safe_mode_i, safe_config_i, active_mask_i, master_core_i, initial_sync_i,
               halt_ack_i, hart_wfi_i, hart_intc_ack_i, timeout_i,
        input  interrupt_halt_o, interrupt_sync_o, single_bus_o, sync_busy_o, sync_done_o, sync_error_o
    );
    modport slave (
        input  safe_mode_i, safe_config_i, active_mask_i, master_core_i, initial_sync_i,
               halt_ack_i, hart_wfi_i, hart_intc_ack_i, timeout_i,
        output interrupt_halt_o, interrupt_sync_o, single_bus_o, sync_busy_o, sync_done_o, sync_error_o
    );
endinterface

// File: rtl/safe_sync_ctrl.sv
// safe_sync_ctrl: lockstep sync controller for a TMR/DMR hart group with registered Moore outputs
// SAFE_SYNC_TIMEOUT_EN enables the per-state watchdog and the ERROR state
module safe_sync_ctrl #(
    parameter int NHARTS    = 3,
    parameter int TIMEOUT_W = 16
) (
    input logic               clk_i,
    input logic               rst_ni,
    safe_sync_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, HALT, WAIT_WFI, INTR_SYNC, SYNC, END_SYNC, ERROR} state_t;
    state_t            state_q, state_d;
    logic [NHARTS-1:0] act_q, act_d, mst_q, mst_d, halt_q, isync_q;
    logic              tmr_q, tmr_d, bus_q, busy_q, done_q;
    int                n_act, n_ack;
    logic              start;
`ifdef SAFE_SYNC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 cnt_en, err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^bus.timeout_i;
`endif
    assign start = bus.safe_mode_i && |(bus.initial_sync_i & bus.master_core_i & bus.active_mask_i)
                   && $onehot(bus.master_core_i) && $countones(bus.active_mask_i) >= 2;
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        mst_d   = mst_q;
        tmr_d   = tmr_q;
        n_act   = $countones(act_q);
        n_ack   = $countones(bus.halt_ack_i & act_q);
        case (state_q)
            IDLE: if (start) begin
                state_d = HALT;
                act_d   = bus.active_mask_i;
                mst_d   = bus.master_core_i;
                tmr_d   = bus.safe_config_i;
            end
            HALT: state_d = !bus.safe_mode_i ? IDLE
                          : (tmr_q ? n_ack > n_act / 2 : n_ack == n_act) ? WAIT_WFI : HALT;
            WAIT_WFI:  state_d = (bus.hart_wfi_i & act_q) == act_q ? INTR_SYNC : WAIT_WFI;
            INTR_SYNC: state_d = (bus.hart_intc_ack_i & act_q) == act_q ? SYNC : INTR_SYNC;
            SYNC:      state_d = (bus.hart_wfi_i & act_q) == act_q && !bus.safe_mode_i ? END_SYNC : SYNC;
            END_SYNC:  state_d = |(bus.hart_intc_ack_i & mst_q)
                                 && (bus.hart_wfi_i & act_q & ~mst_q) == (act_q & ~mst_q) ? IDLE : END_SYNC;
            ERROR:     state_d = !bus.safe_mode_i ? IDLE : ERROR;
            default:   state_d = IDLE;
        endcase
`ifdef SAFE_SYNC_TIMEOUT_EN
        cnt_en = state_q inside {HALT, WAIT_WFI, INTR_SYNC, END_SYNC};
        if (cnt_en && state_d == state_q && bus.timeout_i != '0 && cnt_q + 1'b1 == bus.timeout_i)
            state_d = ERROR;
        cnt_d = (state_d != state_q || !cnt_en) ? '0 : cnt_q + 1'b1;
`endif
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            act_q   <= '0;
            mst_q   <= '0;
            tmr_q   <= 1'b0;
            halt_q  <= '0;
            isync_q <= '0;
            bus_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SAFE_SYNC_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            mst_q   <= mst_d;
            tmr_q   <= tmr_d;
            halt_q  <= state_d == HALT ? act_d & ~mst_d : '0;
            isync_q <= state_d == INTR_SYNC ? act_d : state_d == END_SYNC ? mst_d : '0;
            bus_q   <= state_d inside {INTR_SYNC, SYNC};
            busy_q  <= state_d != IDLE;
            done_q  <= state_q == END_SYNC && state_d == IDLE;
`ifdef SAFE_SYNC_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= state_d == ERROR;
`endif
        end
    end
    assign bus.interrupt_halt_o = halt_q;
    assign bus.interrupt_sync_o = isync_q;
    assign bus.single_bus_o     = bus_q;
    assign bus.sync_busy_o      = busy_q;
    assign bus.sync_done_o      = done_q;
`ifdef SAFE_SYNC_TIMEOUT_EN
    assign bus.sync_error_o     = err_q;
`else
    assign bus.sync_error_o     = 1'b0;
`endif
endmodule
